// File: rtl/field_dispatch_sched_if.sv
// Field-header handshake, decoder index FIFO push/full, retire and status signals
// for field_dispatch_sched.
interface field_dispatch_sched_if;
  logic       in_valid;
  logic [2:0] in_wire_type;
  logic       in_last;
  logic       in_ready;
  logic       varint_idx_full;
  logic       raw_idx_full;
  logic       varint_push;
  logic       raw_push;
  logic [9:0] tag_index;
  logic       idx_fifo_clr;
  logic       retire;
  logic [9:0] outstanding;
  logic       msg_done;
  logic       err_wire_type;
  logic       err_retire;

  modport master (
    output in_valid, in_wire_type, in_last, varint_idx_full, raw_idx_full, retire,
    input  in_ready, varint_push, raw_push, tag_index, idx_fifo_clr, outstanding, msg_done,
           err_wire_type, err_retire
  );

  modport slave (
    input  in_valid, in_wire_type, in_last, varint_idx_full, raw_idx_full, retire,
    output in_ready, varint_push, raw_push, tag_index, idx_fifo_clr, outstanding, msg_done,
           err_wire_type, err_retire
  );
endinterface

// File: rtl/field_dispatch_sched.sv
// Routes parsed protobuf field headers to the varint/raw decoder index FIFOs, stamps
// sequential 10-bit tags, bounds in-flight fields and drains at message boundaries.
module field_dispatch_sched #(
  parameter int unsigned MAX_OUTSTANDING = 1023
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   clear,
  field_dispatch_sched_if.slave bus
);

  localparam logic [9:0] MaxOut = MAX_OUTSTANDING[9:0];

  typedef enum logic [4:0] {
    StInit       = 5'b00001,
    StRun        = 5'b00010,
    StCreditWait = 5'b00100,
    StDrain      = 5'b01000,
    StError      = 5'b10000
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] tag_cnt_q, tag_cnt_d;
  logic [9:0] outstanding_q, outstanding_d;
  logic       last_seen_q, last_seen_d;
  logic       err_wire_type_q, err_wire_type_d;
  logic       err_retire_q, err_retire_d;

  logic path_varint, path_raw, illegal, target_full, credit_ok;
  logic in_ready, msg_done, idx_fifo_clr;
  logic xfer, legal_xfer, retire_ok, retire_stray;

  always_comb begin
    path_varint = (bus.in_wire_type == 3'd0);
    path_raw    = (bus.in_wire_type == 3'd1) || (bus.in_wire_type == 3'd2) ||
                  (bus.in_wire_type == 3'd5);
    illegal     = !(path_varint || path_raw);
    target_full = path_varint ? bus.varint_idx_full :
                  path_raw    ? bus.raw_idx_full    : 1'b0;
    credit_ok   = (outstanding_q < MaxOut);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StInit;
      tag_cnt_q       <= '0;
      outstanding_q   <= '0;
      last_seen_q     <= 1'b0;
      err_wire_type_q <= 1'b0;
      err_retire_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      tag_cnt_q       <= tag_cnt_d;
      outstanding_q   <= outstanding_d;
      last_seen_q     <= last_seen_d;
      err_wire_type_q <= err_wire_type_d;
      err_retire_q    <= err_retire_d;
    end
  end

  // Illegal wire types are consumed (in_ready=1) so the parser never stalls on them.
  always_comb begin
    in_ready     = 1'b0;
    msg_done     = 1'b0;
    idx_fifo_clr = 1'b0;
    unique case (state_q)
      StInit:  idx_fifo_clr = 1'b1;
      StRun:   in_ready = illegal || (!target_full && credit_ok);
      StDrain: msg_done = last_seen_q && (outstanding_q == '0);
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit: state_d = StRun;
      StRun: begin
        if (bus.in_valid) begin
          if (illegal)                    state_d = StError;
          else if (!credit_ok)            state_d = StCreditWait;
          else if (in_ready && bus.in_last) state_d = StDrain;
        end
      end
      StCreditWait: if (credit_ok) state_d = StRun;
      StDrain:      if (msg_done)  state_d = StRun;
      StError:      state_d = StError;
      default:      state_d = StInit;
    endcase
    if (clear) state_d = StInit;
  end

  always_comb begin
    xfer         = bus.in_valid && in_ready;
    legal_xfer   = xfer && !illegal;
    retire_ok    = bus.retire && (state_q != StInit) && (outstanding_q != '0);
    retire_stray = bus.retire && (state_q != StInit) && (outstanding_q == '0);

    tag_cnt_d       = tag_cnt_q;
    outstanding_d   = outstanding_q;
    last_seen_d     = last_seen_q;
    err_wire_type_d = err_wire_type_q;
    err_retire_d    = err_retire_q;

    if (legal_xfer) begin
      tag_cnt_d = (tag_cnt_q == 10'd1023) ? 10'd0 : tag_cnt_q + 10'd1;
      if (bus.in_last) last_seen_d = 1'b1;
    end
    if (legal_xfer && !retire_ok)      outstanding_d = outstanding_q + 10'd1;
    else if (!legal_xfer && retire_ok) outstanding_d = outstanding_q - 10'd1;
    if (xfer && illegal) err_wire_type_d = 1'b1;
    if (retire_stray)    err_retire_d    = 1'b1;
    if (msg_done)        last_seen_d     = 1'b0;

    if (clear || (state_q == StInit)) begin
      tag_cnt_d     = '0;
      outstanding_d = '0;
      last_seen_d   = 1'b0;
    end
    if (clear) begin
      err_wire_type_d = 1'b0;
      err_retire_d    = 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.msg_done      = msg_done;
  assign bus.idx_fifo_clr  = idx_fifo_clr;
  assign bus.varint_push   = legal_xfer && path_varint;
  assign bus.raw_push      = legal_xfer && path_raw;
  assign bus.tag_index     = tag_cnt_q;
  assign bus.outstanding   = outstanding_q;
  assign bus.err_wire_type = err_wire_type_q;
  assign bus.err_retire    = err_retire_q;

endmodule

// File: tb/tb_field_dispatch_sched.sv
// Scoreboard bench for field_dispatch_sched (MAX_OUTSTANDING=4): expected pushes are
// queued at issue time and a negedge monitor checks every push the DUT makes.
module tb_field_dispatch_sched;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   msg_cnt = 0;
  logic [9:0]  exp_tag = '0;
  logic [10:0] exp_q[$];   // {is_raw, tag}

  field_dispatch_sched_if bus ();

  field_dispatch_sched #(.MAX_OUTSTANDING(4)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the push a legal field will produce and advance the model tag.
  task automatic expect_field(input logic [2:0] wt);
    logic is_raw;
    if (wt == 3'd0 || wt == 3'd1 || wt == 3'd2 || wt == 3'd5) begin
      is_raw = (wt != 3'd0);
      exp_q.push_back({is_raw, exp_tag});
      exp_tag = exp_tag + 10'd1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_field(input logic [2:0] wt, input logic last);
    int  n = 0;
    bit  done = 0;
    bus.in_valid     = 1'b1;
    bus.in_wire_type = wt;
    bus.in_last      = last;
    expect_field(wt);
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      else if (++n > 40) begin
        total++;
        bad++;
        $display("FAIL handshake_timeout: got no in_ready expected in_ready within 40 cycles");
        done = 1;
      end
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear   = 1'b0;
    exp_tag = '0;
    @(negedge clk);
    chk("clear_init_fifo_clr", 32'(bus.idx_fifo_clr), 32'd1);
    cyc();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.msg_done) msg_cnt++;
      if (bus.varint_push || bus.raw_push) begin
        logic [10:0] e;
        if (bus.varint_push && bus.raw_push) begin
          total++;
          bad++;
          $display("FAIL both_push: got varint and raw expected one");
        end else if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_push: got tag %0d expected no push", bus.tag_index);
        end else begin
          e = exp_q.pop_front();
          chk("push_path_raw", 32'(bus.raw_push), 32'(e[10]));
          chk("push_tag", 32'(bus.tag_index), 32'(e[9:0]));
        end
      end
    end
  end

  initial begin
    bus.in_valid        = 1'b0;
    bus.in_wire_type    = 3'd0;
    bus.in_last         = 1'b0;
    bus.varint_idx_full = 1'b0;
    bus.raw_idx_full    = 1'b0;
    bus.retire          = 1'b0;

    // Reset values, then one INIT cycle.
    @(negedge clk);
    chk("rst_fifo_clr", 32'(bus.idx_fifo_clr), 32'd1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_tag", 32'(bus.tag_index), 32'd0);
    chk("rst_outstanding", 32'(bus.outstanding), 32'd0);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("init_fifo_clr", 32'(bus.idx_fifo_clr), 32'd1);
    cyc();
    @(negedge clk);
    chk("run_fifo_clr", 32'(bus.idx_fifo_clr), 32'd0);
    cyc();

    // Three back-to-back varint fields.
    for (int i = 0; i < 3; i++) send_field(3'd0, 1'b0);
    @(negedge clk);
    chk("t1_outstanding", 32'(bus.outstanding), 32'd3);
    cyc();

    // Mixed types with the raw FIFO full during the type-2 field.
    do_clear();
    send_field(3'd0, 1'b0);
    bus.raw_idx_full = 1'b1;
    bus.in_valid     = 1'b1;
    bus.in_wire_type = 3'd2;
    expect_field(3'd2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t2_raw_full_block", 32'(bus.in_ready), 32'd0);
      cyc();
    end
    bus.raw_idx_full = 1'b0;
    @(negedge clk);
    chk("t2_raw_unblock", 32'(bus.in_ready), 32'd1);
    cyc();
    bus.in_valid = 1'b0;
    send_field(3'd5, 1'b0);
    send_field(3'd1, 1'b0);
    @(negedge clk);
    chk("t2_outstanding", 32'(bus.outstanding), 32'd4);
    cyc();

    // Credit limit of 4: field 4 waits for the retire in cycle 10.
    do_clear();
    for (int i = 0; i < 4; i++) send_field(3'd0, 1'b0);
    bus.in_valid     = 1'b1;
    bus.in_wire_type = 3'd0;
    expect_field(3'd0);
    for (int c = 4; c <= 11; c++) begin
      bus.retire = (c == 10);
      @(negedge clk);
      chk("t3_credit_block", 32'(bus.in_ready), 32'd0);
      cyc();
    end
    bus.retire = 1'b0;
    @(negedge clk);
    chk("t3_credit_resume", 32'(bus.in_ready), 32'd1);
    cyc();
    expect_field(3'd0);
    bus.retire = 1'b1;
    @(negedge clk);
    chk("t3_full_again", 32'(bus.outstanding), 32'd4);
    cyc();
    bus.retire = 1'b0;
    @(negedge clk);
    chk("t3_after_retire", 32'(bus.outstanding), 32'd3);
    chk("t3_wait_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    bus.retire = 1'b1;
    @(negedge clk);
    chk("t3_xfer_with_retire", 32'(bus.in_ready), 32'd1);
    cyc();
    bus.retire   = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_retire_xfer_hold", 32'(bus.outstanding), 32'd3);
    cyc();

    // Preload tag counter to 1022 with transfer/retire pairs, then wrap.
    do_clear();
    bus.in_wire_type = 3'd0;
    for (int i = 0; i < 1022; i++) begin
      bus.in_valid = 1'b1;
      bus.retire   = (i != 0);
      expect_field(3'd0);
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.retire   = 1'b1;
    cyc();
    bus.retire = 1'b0;
    @(negedge clk);
    chk("t4_preload_drained", 32'(bus.outstanding), 32'd0);
    chk("t4_preload_tag", 32'(bus.tag_index), 32'd1022);
    cyc();
    for (int i = 0; i < 3; i++) send_field(3'd0, 1'b0);
    @(negedge clk);
    chk("t4_wrap_outstanding", 32'(bus.outstanding), 32'd3);
    chk("t4_wrap_tag", 32'(bus.tag_index), 32'd1);
    cyc();

    // Two-field message, retires 5 and 9 cycles after the last transfer.
    do_clear();
    send_field(3'd0, 1'b0);
    send_field(3'd2, 1'b1);
    begin
      int msg0;
      msg0 = msg_cnt;
      for (int k = 1; k <= 12; k++) begin
        bus.retire       = (k == 5) || (k == 9);
        bus.in_valid     = (k < 9);
        bus.in_wire_type = 3'd0;
        @(negedge clk);
        if (k <= 10) chk("t5_drain_ready", 32'(bus.in_ready), 32'd0);
        chk("t5_msg_done", 32'(bus.msg_done), 32'(k == 10));
        cyc();
      end
      chk("t5_msg_done_once", 32'(msg_cnt - msg0), 32'd1);
    end
    bus.retire   = 1'b0;
    bus.in_valid = 1'b0;

    // Illegal wire type, clear recovery, stray retire, reset mid-drain.
    do_clear();
    bus.in_valid     = 1'b1;
    bus.in_wire_type = 3'd6;
    @(negedge clk);
    chk("t6_illegal_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    bus.in_wire_type = 3'd0;
    @(negedge clk);
    chk("t6_err_wire_type", 32'(bus.err_wire_type), 32'd1);
    chk("t6_error_blocks", 32'(bus.in_ready), 32'd0);
    cyc();
    bus.in_valid = 1'b0;
    do_clear();
    @(negedge clk);
    chk("t6_err_cleared", 32'(bus.err_wire_type), 32'd0);
    chk("t6_init_one_cycle", 32'(bus.idx_fifo_clr), 32'd0);
    cyc();
    send_field(3'd0, 1'b0);
    bus.retire = 1'b1;
    cyc();
    @(negedge clk);
    chk("t6_no_err_retire", 32'(bus.err_retire), 32'd0);
    cyc();
    bus.retire = 1'b0;
    @(negedge clk);
    chk("t6_err_retire", 32'(bus.err_retire), 32'd1);
    chk("t6_stray_outstanding", 32'(bus.outstanding), 32'd0);
    cyc();

    do_clear();
    send_field(3'd0, 1'b1);
    @(negedge clk);
    chk("t6_in_drain", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("t6_rst_fifo_clr", 32'(bus.idx_fifo_clr), 32'd1);
    chk("t6_rst_outstanding", 32'(bus.outstanding), 32'd0);
    chk("t6_rst_tag", 32'(bus.tag_index), 32'd0);
    chk("t6_rst_msg_done", 32'(bus.msg_done), 32'd0);
    chk("t6_rst_push", 32'(bus.varint_push | bus.raw_push), 32'd0);
    cyc();
    reset   = 1'b1;
    exp_tag = '0;
    cyc();
    cyc();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/field_dispatch_sched.md
# field_dispatch_sched

Scheduler in front of the protobuf field decoders. It accepts one parsed field header per handshake and routes it to the varint or raw-data decoder index FIFO. Each field is stamped with a sequential 10-bit output index. The block limits in-flight fields so that indices never alias in the downstream in-order merger, which wraps at 1023→0. It also sequences message boundaries by draining all outstanding fields before signalling message completion.

## Interface
- MAX_OUTSTANDING, default 1023: maximum dispatched-but-unretired fields. Legal range 1..1023.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); synchronous deassertion handled externally.
- clear  in  1  synchronous soft reset. Forces INIT on next edge; clears sticky errors.
- in_valid  in  1  field header valid.
- in_wire_type  in  3  protobuf wire type of field.
- in_last  in  1  field is last of current message.
- in_ready  out  1  field accepted when in_valid && in_ready.
- varint_idx_full  in  1  varint decoder index FIFO full.
- raw_idx_full  in  1  raw-data decoder index FIFO full.
- varint_push  out  1  push tag_index into varint index FIFO.
- raw_push  out  1  push tag_index into raw-data index FIFO.
- tag_index  out  10  index of field being pushed; equals tag counter.
- idx_fifo_clr  out  1  clear both decoder index FIFOs.
- retire  in  1  one-cycle pulse per field emitted by merger.
- outstanding  out  10  current in-flight count.
- msg_done  out  1  one-cycle pulse when a message is fully drained.
- err_wire_type  out  1  sticky: illegal wire type seen.
- err_retire  out  1  sticky: retire received with outstanding == 0.

## Operation
- Registers:
  - state: one-hot, 5 states.
  - tag_cnt[9:0]
  - outstanding[9:0]
  - last_seen
  - err_wire_type
  - err_retire
- Reset (reset=0): state=INIT, tag_cnt=0, outstanding=0, last_seen=0, errors=0.
  - Outputs while in reset: idx_fifo_clr=1; in_ready, pushes, msg_done = 0; tag_index=0; outstanding=0.
- Routing by wire type:
  - 0 → varint path.
  - 1, 2, 5 → raw path.
  - 3, 4, 6, 7 → illegal.
- target_full = varint_idx_full for varint path, raw_idx_full for raw path, 0 for illegal.
- credit_ok = (outstanding < MAX_OUTSTANDING).
- States:
  - INIT:
    - idx_fifo_clr=1; tag_cnt←0, outstanding←0, last_seen←0.
    - Next state: RUN.
  - RUN:
    - in_ready = ~target_full && credit_ok; pushes asserted combinationally in the transfer cycle.
    - Legal transfer: tag_cnt←(tag_cnt==1023)?0:tag_cnt+1; outstanding increments.
    - Transfer with in_last=1: next state DRAIN.
    - Illegal type: in_ready=1, field consumed, no push, tag_cnt unchanged, err_wire_type←1, next state ERROR.
    - in_valid && credit_ok==0: next state CREDIT_WAIT.
    - Otherwise: stay in RUN.
  - CREDIT_WAIT:
    - in_ready=0.
    - Return to RUN on the cycle after outstanding < MAX_OUTSTANDING.
  - DRAIN:
    - in_ready=0.
    - When outstanding==0: msg_done=1 for one cycle, next state RUN.
  - ERROR:
    - in_ready=0, no pushes; holds until clear.
- Retire handling (all states except INIT):
  - outstanding decrements.
  - Retire in the same cycle as a transfer: outstanding unchanged.
  - Retire with outstanding==0: ignored, err_retire←1.
- Exactly one of varint_push/raw_push is asserted per legal transfer; never both.
- clear has priority over every transition. clear mid-message discards tags and counts.
- A state encoding outside the one-hot set goes to INIT.

## Timing
- Dispatch latency is 0: push and tag_index are valid in the handshake cycle.
- tag_cnt and outstanding update on the following edge.
- in_ready depends combinationally on the FIFO full flags, in_wire_type and state.
- No combinational path from in_valid to in_ready.
- msg_done occurs no earlier than 1 cycle after the last-field transfer, even if its retire arrives in the same cycle.
- Wrap: tag 1023 is followed by tag 0; outstanding is unaffected by the tag wrap.
- INIT lasts exactly one cycle after reset release or clear.

## Test plan
- **Reset release, then 3 varint fields (type 0) back-to-back, no full flags:** varint_push on 3 consecutive cycles with tag_index 0,1,2; outstanding=3; raw_push never asserted.
- **Mixed types 0,2,5,1 with raw_idx_full=1 held for 4 cycles during type 2:** in_ready=0 for those 4 cycles; tags 0,1,2,3 stay strictly in order; no tag skipped.
- **MAX_OUTSTANDING=4, 6 fields offered, retire pulsed once at cycle 10:**
  - Fields 0–3 accepted; CREDIT_WAIT entered; field 4 accepted only after the retire.
  - Simultaneous retire and transfer leaves outstanding unchanged.
- **Preload tag_cnt to 1022 via 1022 transfer/retire pairs, then 3 fields:** tags 1022,1023,0; outstanding never exceeds 3.
- **Message of 2 fields (second has in_last=1), retires at cycles +5 and +9:** in_ready=0 during DRAIN; msg_done pulses exactly once, 1 cycle after the second retire.
- **Wire type 6 offered, then clear; also retire with outstanding=0; also reset asserted mid-DRAIN:**
  - Type 6: err_wire_type=1, ERROR state, no push; clear → INIT with idx_fifo_clr=1 for one cycle, then RUN with tag 0.
  - Stray retire: err_retire=1, outstanding stays 0.
  - Reset mid-DRAIN: all outputs return to their reset values immediately.
